shift_add_sequencer: RTL and testbench

//  Sequential shift-and-add unsigned multiplier controller; upstream and downstream neighbour of the adder stage.

---
 rtl/multiplier_pkg.sv | 14 +
 rtl/shift_add_sequencer.sv | 110 +++++++++++
 tb/tb_shift_add_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and defaults for the shift-and-add multiplier
// Purpose : sequencer state encoding and the default accumulator/product width.
// Ports   : none (package).
package multiplier_pkg;

    localparam int WORD_LENGTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_add_sequencer.sv
// rtl/shift_add_sequencer.sv - shift-and-add unsigned multiplier controller around an external adder
// Purpose : multiplies two Word_Length/2-bit unsigned operands, one partial product per cycle,
//           using a sibling combinational adder stage for every accumulation.
// Ports   : clk, reset (sync, active-high)
//           Start / Ready            operand handshake, Multiplicand / Multiplier latched on accept
//           Add_Operand / Acc_Value  operands presented to the adder (Data_Add / Data_Input)
//           Adder_Result             adder Data_Output, consumed in the same cycle
//           Done / Product           one-cycle completion pulse and held product
module shift_add_sequencer
    import multiplier_pkg::*;
#(
    parameter int Word_Length = WORD_LENGTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Start,
    input  logic [Word_Length/2-1:0]   Multiplicand,
    input  logic [Word_Length/2-1:0]   Multiplier,
    input  logic [Word_Length-1:0]     Adder_Result,
    output logic [Word_Length-1:0]     Add_Operand,
    output logic [Word_Length-1:0]     Acc_Value,
    output logic                       Ready,
    output logic                       Done,
    output logic [Word_Length-1:0]     Product
);

    localparam int Operand_Length = Word_Length / 2;
    localparam int Count_Width    = $clog2(Operand_Length + 1);
    localparam logic [Count_Width-1:0] LAST_COUNT = Count_Width'(Operand_Length - 1);

    if (Word_Length % 2 != 0) begin : g_bad_width
        $error("shift_add_sequencer: Word_Length must be even");
    end

    seq_state_t                 state_q;
    logic [Word_Length-1:0]     mcand_q;
    logic [Operand_Length-1:0]  mplr_q;
    logic [Word_Length-1:0]     acc_q;
    logic [Word_Length-1:0]     acc_d;
    logic [Count_Width-1:0]     count_q;
    logic [Word_Length-1:0]     product_q;
    logic                       done_q;
    logic                       ready_q;

    // The adder returns Data_Add when both inputs are equal; the accumulator is always a sum of
    // strictly smaller shifted multiplicands, so equality only happens at 0+0 and needs no fixup.
    always_comb begin
        acc_d = acc_q;
        if (mplr_q[0]) begin
            acc_d = Adder_Result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        mcand_q <= {{Operand_Length{1'b0}}, Multiplicand};
                        mplr_q  <= Multiplier;
                        acc_q   <= '0;
                        count_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    count_q <= count_q + Count_Width'(1);
                    // Final partial product: publish the just-computed sum so Product is valid
                    // in the same cycle Done is high.
                    if (count_q == LAST_COUNT) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Add_Operand = mcand_q;
    assign Acc_Value   = acc_q;
    assign Ready       = ready_q;
    assign Done        = done_q;
    assign Product     = product_q;

endmodule

// File: tb/tb_shift_add_sequencer.sv
// tb/tb_shift_add_sequencer.sv - self-checking bench for shift_add_sequencer with a modelled adder stage
module tb_shift_add_sequencer;

    localparam int WL = 16;
    localparam int OL = WL / 2;

    logic          clk;
    logic          reset;
    logic          Start;
    logic [OL-1:0] Multiplicand;
    logic [OL-1:0] Multiplier;
    logic [WL-1:0] Adder_Result;
    logic [WL-1:0] Add_Operand;
    logic [WL-1:0] Acc_Value;
    logic          Ready;
    logic          Done;
    logic [WL-1:0] Product;

    typedef struct {
        logic [WL-1:0] prod;
        int            done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    logic prev_done;

    shift_add_sequencer #(.Word_Length(WL)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Adder_Result (Adder_Result),
        .Add_Operand  (Add_Operand),
        .Acc_Value    (Acc_Value),
        .Ready        (Ready),
        .Done         (Done),
        .Product      (Product)
    );

    // Adder stage: plain sum, except it returns Data_Add when both inputs match.
    assign Adder_Result = (Add_Operand == Acc_Value) ? Add_Operand : Add_Operand + Acc_Value;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every Done must match the oldest expected product and its cycle.
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("product", {16'd0, Product}, {16'd0, e.prod});
                check("latency", cyc, e.done_cyc);
            end
        end
        prev_done = Done;
    end

    task automatic issue(input logic [OL-1:0] a, input logic [OL-1:0] b);
        exp_t e;
        @(negedge clk);
        Start = 1'b1;
        Multiplicand = a;
        Multiplier = b;
        e.prod = WL'(int'(a) * int'(b));
        e.done_cyc = cyc + 1 + OL;
        sb.push_back(e);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || Ready !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (sb.size() == 0 && Ready === 1'b1)}, 32'd1);
    endtask

    initial begin
        int lo;
        int t0;
        exp_t e;
        n_checks = 0;
        n_pass = 0;
        prev_done = 1'b0;
        cyc = 0;
        reset = 1'b1;
        Start = 1'b0;
        Multiplicand = '0;
        Multiplier = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_ready", {31'd0, Ready}, 32'd1);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_product", {16'd0, Product}, 32'd0);
        check("rst_add_operand", {16'd0, Add_Operand}, 32'd0);
        check("rst_acc_value", {16'd0, Acc_Value}, 32'd0);

        // 13 x 11 with Ready-low duration
        issue(8'd13, 8'd11);
        lo = 0;
        while (Ready === 1'b0 && lo < 50) begin
            lo++;
            @(negedge clk);
        end
        check("ready_low_cycles", lo, OL + 1);
        drain("drain_13x11");
        @(negedge clk);
        check("product_held", {16'd0, Product}, 32'h008F);

        issue(8'd255, 8'd255);
        drain("drain_255x255");
        issue(8'd0, 8'd200);
        drain("drain_0x200");
        issue(8'd200, 8'd0);
        drain("drain_200x0");

        // Start re-pulsed during RUN is ignored
        issue(8'd3, 8'd5);
        repeat (2) @(negedge clk);
        Start = 1'b1;
        Multiplicand = 8'd7;
        Multiplier = 8'd7;
        @(negedge clk);
        Start = 1'b0;
        drain("drain_repulse");
        repeat (12) @(negedge clk);
        check("repulse_product", {16'd0, Product}, 32'h000F);

        // Start held high: two back-to-back operations, OL+2 cycles apart
        @(negedge clk);
        Start = 1'b1;
        Multiplicand = 8'd2;
        Multiplier = 8'd3;
        t0 = cyc + 1;
        e.prod = 16'd6;
        e.done_cyc = t0 + OL;
        sb.push_back(e);
        e.prod = 16'd16;
        e.done_cyc = t0 + OL + 2 + OL;
        sb.push_back(e);
        @(negedge clk);
        Multiplicand = 8'd4;
        Multiplier = 8'd4;
        lo = 0;
        while (cyc < t0 + OL + 2 && lo < 50) begin
            @(negedge clk);
            lo++;
        end
        Start = 1'b0;
        drain("drain_held");

        // Reset during RUN aborts with no Done
        issue(8'd9, 8'd9);
        repeat (3) @(negedge clk);
        void'(sb.pop_back());
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", {31'd0, Ready}, 32'd1);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_product", {16'd0, Product}, 32'd0);
        repeat (20) @(negedge clk);
        check("abort_idle", {31'd0, Ready}, 32'd1);

        // Random operands vs reference product
        for (int i = 0; i < 1000; i++) begin
            issue(OL'($urandom_range(0, 255)), OL'($urandom_range(0, 255)));
            drain("drain_random");
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
